ps2_block_packer: RTL and testbench

Upstream stage of the rsa block. Collects ASCII bytes arriving from the PS/2 keyboard decoder and packs them MSB-first into 128-bit blocks. Presents each block on a valid/ready interface that drives the rsa block's rsa_data_i / rsa_valid_i / rsa_ready_o. The PS/2 side cannot be back-pressured, so the block provides one block of buffering and sticky overflow detection.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_block_packer.sv | 138 +++++++++++++
 tb/tb_ps2_block_packer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2-to-RSA block packer.
package ps2_pkg;

    localparam int BLK_W_DEF = 128;
    localparam int BLK_BYTES = BLK_W_DEF / 8;
    localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

    typedef logic [4:0] byte_cnt_t;

    typedef enum logic {
        S_FILL,
        S_HOLD
    } asm_state_e;

endpackage

// File: rtl/ps2_block_packer.sv
// Packs PS/2 key bytes MSB-first into BLK_W-bit blocks behind a one-entry output slot.
// Latency: last byte of a block in cycle N -> blk_valid_o at N+2; bytes arriving while the block is held are dropped (sticky overflow_o).
module ps2_block_packer
    import ps2_pkg::*;
#(
    parameter int         BLK_W    = BLK_W_DEF,
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data_i,
    input  logic             ps2_valid_i,
    input  logic             ps2_done,
    input  logic             ps2_reset,
    output logic [BLK_W-1:0] blk_data_o,
    output logic             blk_valid_o,
    input  logic             blk_ready_i,
    output logic             blk_last_o,
    output logic [4:0]       blk_bytes_o,
    output logic             overflow_o
);

    localparam int NB = BLK_W / 8;
    localparam logic [BLK_W-1:0] PAD_BLK = {NB{PAD_BYTE}};
    localparam byte_cnt_t NB_CNT = byte_cnt_t'(NB);

    asm_state_e       state_q, state_d;
    logic [BLK_W-1:0] asm_q, asm_d;
    byte_cnt_t        cnt_q, cnt_d;
    logic             closed_q, closed_d;
    logic             pend_last_q, pend_last_d;
    logic [BLK_W-1:0] out_dat_q, out_dat_d;
    logic             out_vld_q, out_vld_d;
    logic             out_last_q, out_last_d;
    byte_cnt_t        out_bytes_q, out_bytes_d;
    logic             ovf_q, ovf_d;

    byte_cnt_t cnt_fill;
    logic      slot_free;

    always_ff @(posedge clk) begin
        if (rst || ps2_reset) begin
            state_q     <= S_FILL;
            asm_q       <= PAD_BLK;
            cnt_q       <= '0;
            closed_q    <= 1'b0;
            pend_last_q <= 1'b0;
            out_dat_q   <= PAD_BLK;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_bytes_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            closed_q    <= closed_d;
            pend_last_q <= pend_last_d;
            out_dat_q   <= out_dat_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            out_bytes_q <= out_bytes_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        closed_d    = closed_q;
        pend_last_d = pend_last_q;
        out_dat_d   = out_dat_q;
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        out_bytes_d = out_bytes_q;
        ovf_d       = ovf_q;

        slot_free = !out_vld_q || blk_ready_i;
        cnt_fill  = cnt_q + byte_cnt_t'(ps2_valid_i);

        if (out_vld_q && blk_ready_i) begin
            out_vld_d = 1'b0;
        end

        unique case (state_q)
            S_FILL: begin
                if (ps2_valid_i) begin
                    for (int k = 0; k < NB; k++) begin
                        if (cnt_q == byte_cnt_t'(k)) begin
                            asm_d[BLK_W-1-8*k -: 8] = ps2_data_i;
                        end
                    end
                    cnt_d = cnt_fill;
                end
                if (cnt_fill == NB_CNT) begin
                    state_d = S_HOLD;
                end
                if (ps2_done) begin
                    if (cnt_fill != '0) begin
                        state_d  = S_HOLD;
                        closed_d = 1'b1;
                    end else if (out_vld_q && !blk_ready_i) begin
                        // Empty message end: tag the block still waiting in the slot.
                        out_last_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (ps2_valid_i) begin
                    ovf_d = 1'b1;
                end
                if (ps2_done) begin
                    pend_last_d = 1'b1;
                end
                if (slot_free) begin
                    out_dat_d   = asm_q;
                    out_vld_d   = 1'b1;
                    out_bytes_d = cnt_q;
                    out_last_d  = closed_q || pend_last_q || ps2_done;
                    asm_d       = PAD_BLK;
                    cnt_d       = '0;
                    closed_d    = 1'b0;
                    pend_last_d = 1'b0;
                    state_d     = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign blk_data_o  = out_dat_q;
    assign blk_valid_o = out_vld_q;
    assign blk_last_o  = out_last_q;
    assign blk_bytes_o = out_bytes_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ps2_block_packer.sv
// Directed bench for ps2_block_packer: packing, short blocks, backpressure, overflow and resets.
module tb_ps2_block_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   ps2_data_i;
    logic         ps2_valid_i;
    logic         ps2_done;
    logic         ps2_reset;
    logic [127:0] blk_data_o;
    logic         blk_valid_o;
    logic         blk_ready_i;
    logic         blk_last_o;
    logic [4:0]   blk_bytes_o;
    logic         overflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_block_packer dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_data_i  (ps2_data_i),
        .ps2_valid_i (ps2_valid_i),
        .ps2_done    (ps2_done),
        .ps2_reset   (ps2_reset),
        .blk_data_o  (blk_data_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_last_o  (blk_last_o),
        .blk_bytes_o (blk_bytes_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        ps2_data_i  = b;
        ps2_valid_i = 1'b1;
        step();
        ps2_valid_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        ps2_data_i  = 8'h00;
        ps2_valid_i = 1'b0;
        ps2_done    = 1'b0;
        ps2_reset   = 1'b0;
        blk_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 128'(blk_valid_o), 128'd0);
        chk("rst_last",  128'(blk_last_o),  128'd0);
        chk("rst_ovf",   128'(overflow_o),  128'd0);
        chk("rst_bytes", 128'(blk_bytes_o), 128'd0);
        chk("rst_data",  blk_data_o,        128'd0);

        // Full block 00..0F, consumer always ready
        blk_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("full_n1_valid", 128'(blk_valid_o), 128'd0);
        step();
        chk("full_valid", 128'(blk_valid_o), 128'd1);
        chk("full_data",  blk_data_o, 128'h000102030405060708090A0B0C0D0E0F);
        chk("full_bytes", 128'(blk_bytes_o), 128'd16);
        chk("full_last",  128'(blk_last_o),  128'd0);
        step();
        chk("full_one_cycle", 128'(blk_valid_o), 128'd0);

        // Short block AA BB CC + done
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        ps2_done = 1'b1;
        step();
        ps2_done = 1'b0;
        chk("short_n1_valid", 128'(blk_valid_o), 128'd0);
        step();
        chk("short_valid", 128'(blk_valid_o), 128'd1);
        chk("short_data",  blk_data_o, 128'hAABBCC00_00000000_00000000_00000000);
        chk("short_bytes", 128'(blk_bytes_o), 128'd3);
        chk("short_last",  128'(blk_last_o),  128'd1);
        step();

        // Byte and done in the same cycle
        ps2_done = 1'b1;
        send(8'h41);
        ps2_done = 1'b0;
        step();
        chk("same_valid", 128'(blk_valid_o), 128'd1);
        chk("same_data",  blk_data_o, 128'h41000000_00000000_00000000_00000000);
        chk("same_bytes", 128'(blk_bytes_o), 128'd1);
        chk("same_last",  128'(blk_last_o),  128'd1);
        step();
        chk("same_gone", 128'(blk_valid_o), 128'd0);

        // Backpressure: two blocks buffered, 33rd byte dropped
        blk_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
        step();
        step();
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
        step();
        chk("bp_held_valid", 128'(blk_valid_o), 128'd1);
        chk("bp_held_data",  blk_data_o, 128'h20212223_24252627_28292A2B_2C2D2E2F);
        chk("bp_ovf_before", 128'(overflow_o), 128'd0);
        send(8'h40);
        chk("bp_ovf_set",    128'(overflow_o), 128'd1);
        chk("bp_still_data", blk_data_o, 128'h20212223_24252627_28292A2B_2C2D2E2F);
        blk_ready_i = 1'b1;
        step();
        chk("bp_b2_valid", 128'(blk_valid_o), 128'd1);
        chk("bp_b2_data",  blk_data_o, 128'h30313233_34353637_38393A3B_3C3D3E3F);
        chk("bp_b2_bytes", 128'(blk_bytes_o), 128'd16);
        chk("bp_b2_last",  128'(blk_last_o),  128'd0);
        step();
        chk("bp_drained",  128'(blk_valid_o), 128'd0);
        chk("bp_ovf_sticky", 128'(overflow_o), 128'd1);

        // ps2_reset with a held block and a partial assembly
        blk_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h50 + 8'(i));
        step();
        step();
        chk("sr_held_valid", 128'(blk_valid_o), 128'd1);
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
        ps2_reset = 1'b1;
        ps2_done  = 1'b1;
        send(8'h99);
        ps2_reset = 1'b0;
        ps2_done  = 1'b0;
        chk("sr_valid", 128'(blk_valid_o), 128'd0);
        chk("sr_ovf",   128'(overflow_o),  128'd0);
        chk("sr_data",  blk_data_o,        128'd0);
        blk_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h70 + 8'(i));
        step();
        chk("sr_blk_valid", 128'(blk_valid_o), 128'd1);
        chk("sr_blk_data",  blk_data_o, 128'h70717273_74757677_78797A7B_7C7D7E7F);
        chk("sr_blk_last",  128'(blk_last_o), 128'd0);
        step();

        // rst mid-block, then done on an empty assembly
        for (int i = 0; i < 7; i++) send(8'h80 + 8'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", 128'(blk_valid_o), 128'd0);
        chk("mr_data",  blk_data_o, 128'd0);
        ps2_done = 1'b1;
        step();
        ps2_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_block", 128'(blk_valid_o), 128'd0);
            step();
        end
        chk("mr_bytes", 128'(blk_bytes_o), 128'd0);
        chk("mr_last",  128'(blk_last_o),  128'd0);
        chk("mr_ovf",   128'(overflow_o),  128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
